// File: rtl/blk_crc_seq_ctrl.sv
// -----------------------------------------------------------------------------
// blk_crc_seq_ctrl
// Accepts one TBS-bit transport block and serialises it MSB-first, followed by
// its 24-bit CRC24A (poly 0x864CFB, init 0, no reflection, no final XOR).
// The output is a valid/ready bit stream that tolerates stalls of any length.
//
// Optional feature: define BLK_CRC_SEQ_PAR_OUT_EN to add a parallel CRC output
// (o_crc / o_crc_valid).
//
// Ports:
//   i_clk_crc    rising-edge clock
//   i_rst_crc    asynchronous active-low reset
//   i_blk_data   transport block, bit TBS-1 sent first
//   i_blk_valid  upstream offers a block
//   o_blk_ready  controller idle and able to accept a block
//   o_bit        serial output: data bits, then CRC bits
//   o_bit_valid  o_bit is valid
//   i_bit_ready  downstream accepts o_bit
//   o_bit_last   high on the final CRC bit (CRC bit 0)
//   o_busy       controller is not idle
//   o_done       one-cycle pulse after the last beat is accepted
//   o_crc        (optional) final CRC, held until the next acceptance
//   o_crc_valid  (optional) one-cycle pulse when o_crc is updated
// -----------------------------------------------------------------------------
module blk_crc_seq_ctrl #(
  parameter int unsigned TBS = 40
) (
  input  logic           i_clk_crc,
  input  logic           i_rst_crc,
  input  logic [TBS-1:0] i_blk_data,
  input  logic           i_blk_valid,
  output logic           o_blk_ready,
  output logic           o_bit,
  output logic           o_bit_valid,
  input  logic           i_bit_ready,
  output logic           o_bit_last,
  output logic           o_busy,
  output logic           o_done
`ifdef BLK_CRC_SEQ_PAR_OUT_EN
  ,
  output logic [23:0]    o_crc,
  output logic           o_crc_valid
`endif
);

  localparam int unsigned CRC_W = 24;
  localparam int unsigned CNT_W = $clog2(TBS + CRC_W);
  localparam logic [CRC_W-1:0] POLY      = 24'h864CFB;
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(TBS - 1);
  localparam logic [CNT_W-1:0] CRC_LAST  = CNT_W'(CRC_W - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    CRC  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CRC_W-1:0] crc_q, crc_d;
  logic [TBS-1:0]   data_q, data_d;
  logic             beat;
  logic             accept;
  logic             crc_final;
  logic             done_d;
  logic             bit_d;
  logic             last_d;
  logic [4:0]       crc_idx;

  // A beat is a bit handed downstream; nothing advances without one.
  assign beat = o_bit_valid && i_bit_ready;

  // Next-state, counter, CRC and data-shift logic.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    crc_d     = crc_q;
    data_d    = data_q;
    accept    = 1'b0;
    crc_final = 1'b0;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_blk_valid) begin
          accept  = 1'b1;
          data_d  = i_blk_data;
          crc_d   = '0;
          cnt_d   = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        if (beat) begin
          // Data is shifted so the bit on the wire is always data_q[TBS-1].
          data_d = data_q << 1;
          crc_d  = {crc_q[CRC_W-2:0], 1'b0} ^ ((crc_q[CRC_W-1] ^ o_bit) ? POLY : '0);
          if (cnt_q == DATA_LAST) begin
            cnt_d     = '0;
            crc_final = 1'b1;
            state_d   = CRC;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      CRC: begin
        if (beat) begin
          if (cnt_q == CRC_LAST) begin
            cnt_d   = '0;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Registered outputs are computed from next-state values so they line up
  // with the state they describe.
  always_comb begin
    crc_idx = 5'(CRC_LAST - cnt_d);
    bit_d   = 1'b0;
    last_d  = 1'b0;
    case (state_d)
      DATA:    bit_d = data_d[TBS-1];
      CRC: begin
        bit_d  = crc_d[crc_idx];
        last_d = (cnt_d == CRC_LAST);
      end
      default: bit_d = 1'b0;
    endcase
  end

  // State, datapath and output registers.
  always_ff @(posedge i_clk_crc or negedge i_rst_crc) begin
    if (!i_rst_crc) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      crc_q       <= '0;
      data_q      <= '0;
      o_blk_ready <= 1'b0;
      o_bit       <= 1'b0;
      o_bit_valid <= 1'b0;
      o_bit_last  <= 1'b0;
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      crc_q       <= crc_d;
      data_q      <= data_d;
      o_blk_ready <= (state_d == IDLE);
      o_bit       <= bit_d;
      o_bit_valid <= (state_d != IDLE);
      o_bit_last  <= last_d;
      o_busy      <= (state_d != IDLE);
      o_done      <= done_d;
    end
  end

`ifdef BLK_CRC_SEQ_PAR_OUT_EN
  // Parallel CRC: captured when the last data bit is consumed, cleared on the
  // next acceptance.
  always_ff @(posedge i_clk_crc or negedge i_rst_crc) begin
    if (!i_rst_crc) begin
      o_crc       <= '0;
      o_crc_valid <= 1'b0;
    end else begin
      o_crc_valid <= crc_final;
      if (accept) begin
        o_crc <= '0;
      end else if (crc_final) begin
        o_crc <= crc_d;
      end
    end
  end
`endif

endmodule

// File: tb/tb_blk_crc_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_blk_crc_seq_ctrl
// Directed bench for blk_crc_seq_ctrl: one TBS=40 instance and one TBS=1
// instance sharing clock and reset. Expected bit sequences are hand-derived.
// -----------------------------------------------------------------------------
module tb_blk_crc_seq_ctrl;

  logic clk = 1'b0;
  logic rst_n;

  // TBS = 40 instance
  logic [39:0] blk_data_a;
  logic        blk_valid_a, blk_ready_a, bit_a, bit_valid_a, bit_ready_a;
  logic        bit_last_a, busy_a, done_a;
  // TBS = 1 instance
  logic [0:0]  blk_data_b;
  logic        blk_valid_b, blk_ready_b, bit_b, bit_valid_b, bit_ready_b;
  logic        bit_last_b, busy_b, done_b;
`ifdef BLK_CRC_SEQ_PAR_OUT_EN
  logic [23:0] crc_a, crc_b;
  logic        crc_valid_a, crc_valid_b;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  blk_crc_seq_ctrl #(.TBS(40)) u_dut_a (
    .i_clk_crc   (clk),
    .i_rst_crc   (rst_n),
    .i_blk_data  (blk_data_a),
    .i_blk_valid (blk_valid_a),
    .o_blk_ready (blk_ready_a),
    .o_bit       (bit_a),
    .o_bit_valid (bit_valid_a),
    .i_bit_ready (bit_ready_a),
    .o_bit_last  (bit_last_a),
    .o_busy      (busy_a),
    .o_done      (done_a)
`ifdef BLK_CRC_SEQ_PAR_OUT_EN
    ,
    .o_crc       (crc_a),
    .o_crc_valid (crc_valid_a)
`endif
  );

  blk_crc_seq_ctrl #(.TBS(1)) u_dut_b (
    .i_clk_crc   (clk),
    .i_rst_crc   (rst_n),
    .i_blk_data  (blk_data_b),
    .i_blk_valid (blk_valid_b),
    .o_blk_ready (blk_ready_b),
    .o_bit       (bit_b),
    .o_bit_valid (bit_valid_b),
    .i_bit_ready (bit_ready_b),
    .o_bit_last  (bit_last_b),
    .o_busy      (busy_b),
    .o_done      (done_b)
`ifdef BLK_CRC_SEQ_PAR_OUT_EN
    ,
    .o_crc       (crc_b),
    .o_crc_valid (crc_valid_b)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Offer a block on instance A and return on the negedge after acceptance.
  task automatic accept_a(input logic [39:0] blk);
    int cyc;
    cyc         = 0;
    blk_data_a  = blk;
    blk_valid_a = 1'b1;
    while (!blk_ready_a && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    chk("accept_ready", 64'(blk_ready_a), 64'd1);
    @(negedge clk);
    blk_valid_a = 1'b0;
  endtask

  // Collect up to stop_at beats from instance A; bad counts protocol slips
  // (valid drop, ready/busy wrong, o_bit moving during a stall, misplaced last).
  task automatic collect_a(input bit rnd, input int stop_at,
                           output logic [63:0] seq, output int beats, output int bad);
    int   cyc;
    bit   stalled;
    logic prev;
    seq = '0; beats = 0; bad = 0; stalled = 1'b0; prev = 1'b0; cyc = 0;
    while (!bit_valid_a && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    while (beats < stop_at && cyc < 4000) begin
      if (!bit_valid_a || blk_ready_a || !busy_a) bad++;
      if (stalled && (bit_a !== prev)) bad++;
      if (bit_last_a !== 1'(beats == 63)) bad++;
      bit_ready_a = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (bit_ready_a) begin
        seq[63-beats] = bit_a;
        beats++;
        stalled = 1'b0;
      end else begin
        stalled = 1'b1;
      end
      prev = bit_a;
      @(negedge clk);
      cyc++;
    end
    bit_ready_a = 1'b1;
  endtask

  initial begin
    logic [63:0] seq;
    logic [24:0] seq_b;
    int          beats, bad, nb, cyc, done_seen;

    rst_n       = 1'b0;
    blk_data_a  = '0; blk_valid_a = 1'b0; bit_ready_a = 1'b1;
    blk_data_b  = '0; blk_valid_b = 1'b0; bit_ready_b = 1'b1;
    #1;
    chk("reset_outs_a", 64'({blk_ready_a, bit_a, bit_valid_a, bit_last_a, busy_a, done_a}), 64'd0);
    chk("reset_outs_b", 64'({blk_ready_b, bit_b, bit_valid_b, bit_last_b, busy_b, done_b}), 64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("ready_after_rst_a", 64'(blk_ready_a), 64'd1);
    chk("ready_after_rst_b", 64'(blk_ready_b), 64'd1);

    // All-zero block: 64 zero beats, last on beat 64, done next cycle.
    accept_a(40'h0);
    collect_a(1'b0, 64, seq, beats, bad);
    chk("zero_seq", seq, 64'd0);
    chk("zero_beats", 64'(beats), 64'd64);
    chk("zero_proto", 64'(bad), 64'd0);
    chk("zero_done", 64'({done_a, busy_a}), 64'b10);
    @(negedge clk);
    chk("zero_done_pulse", 64'(done_a), 64'd0);

    // Single trailing one: CRC is the polynomial itself.
    accept_a(40'h0000000001);
    collect_a(1'b0, 64, seq, beats, bad);
    chk("one_seq", seq, {40'h0000000001, 24'h864CFB});
    chk("one_proto", 64'(bad), 64'd0);
    chk("one_done", 64'(done_a), 64'd1);
`ifdef BLK_CRC_SEQ_PAR_OUT_EN
    chk("one_par_crc", 64'(crc_a), 64'h864CFB);
`endif
    @(negedge clk);

    // Same vector with random downstream stalls.
    accept_a(40'h0000000001);
    collect_a(1'b1, 64, seq, beats, bad);
    chk("stall_seq", seq, {40'h0000000001, 24'h864CFB});
    chk("stall_beats", 64'(beats), 64'd64);
    chk("stall_proto", 64'(bad), 64'd0);
    chk("stall_done", 64'(done_a), 64'd1);
    @(negedge clk);

    // Valid held high with a different block while busy.
    accept_a(40'h0000000001);
    blk_data_a  = 40'h0000000002;
    blk_valid_a = 1'b1;
    collect_a(1'b0, 64, seq, beats, bad);
    chk("held_first_seq", seq, {40'h0000000001, 24'h864CFB});
    chk("held_first_proto", 64'(bad), 64'd0);
    chk("held_first_done", 64'(done_a), 64'd1);
    @(negedge clk);
    blk_valid_a = 1'b0;
    chk("held_second_accepted", 64'(busy_a), 64'd1);
    collect_a(1'b0, 64, seq, beats, bad);
    chk("held_second_seq", seq, {40'h0000000002, 24'h8AD50D});
    chk("held_second_done", 64'(done_a), 64'd1);
    @(negedge clk);

    // Reset at beat 30 aborts the block; next block is clean.
    accept_a(40'h0000000001);
    collect_a(1'b0, 30, seq, beats, bad);
    chk("abort_beats", 64'(beats), 64'd30);
    rst_n = 1'b0;
    #1;
    chk("abort_outs", 64'({blk_ready_a, bit_a, bit_valid_a, bit_last_a, busy_a, done_a}), 64'd0);
`ifdef BLK_CRC_SEQ_PAR_OUT_EN
    chk("abort_par_crc", 64'(crc_a), 64'd0);
`endif
    repeat (2) @(negedge clk);
    rst_n     = 1'b1;
    done_seen = 0;
    for (int i = 0; i < 70; i++) begin
      @(negedge clk);
      if (done_a || busy_a) done_seen++;
    end
    chk("abort_no_done", 64'(done_seen), 64'd0);
    accept_a(40'h0000000001);
    collect_a(1'b0, 64, seq, beats, bad);
    chk("after_abort_seq", seq, {40'h0000000001, 24'h864CFB});
    chk("after_abort_done", 64'(done_a), 64'd1);
    @(negedge clk);

    // TBS = 1: one data bit then the polynomial.
    blk_data_b  = 1'b1;
    blk_valid_b = 1'b1;
    cyc = 0;
    while (!blk_ready_b && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    @(negedge clk);
    blk_valid_b = 1'b0;
    seq_b = '0; nb = 0; bad = 0; cyc = 0;
    while (nb < 25 && cyc < 200) begin
      if (bit_valid_b) begin
        if (bit_last_b !== 1'(nb == 24)) bad++;
        seq_b[24-nb] = bit_b;
        nb++;
      end
      @(negedge clk);
      cyc++;
    end
    chk("tbs1_seq", 64'(seq_b), 64'({1'b1, 24'h864CFB}));
    chk("tbs1_beats", 64'(nb), 64'd25);
    chk("tbs1_last", 64'(bad), 64'd0);
    chk("tbs1_done", 64'({done_b, busy_b}), 64'b10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
